// File: rtl/if_id_stage_pkg.sv
// Shared control header for the RV32I core: immediate-extender selects,
// base opcodes and the canonical bubble instruction.
package if_id_stage_pkg;

  localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b000001;
  localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b000010;
  localparam logic [5:0] EXT_CTRL_STYPE       = 6'b000100;
  localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b001000;
  localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b010000;
  localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b100000;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // slli/srli/srai carry a 5-bit shift amount instead of a 12-bit immediate
  function automatic logic is_shift_funct3(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/if_id_stage_imm_field_dec.sv
// Combinational slicing of the registered instruction into immediate fields,
// plus the extender select and an illegal-opcode flag.
module imm_field_dec
  import if_id_stage_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        valid,
  output logic [4:0]  iimm_shamt,
  output logic [11:0] iimm,
  output logic [11:0] simm,
  output logic [11:0] bimm,
  output logic [19:0] uimm,
  output logic [19:0] jimm,
  output logic [5:0]  ext_op,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign iimm_shamt = inst[24:20];
  assign iimm       = inst[31:20];
  assign simm       = {inst[31:25], inst[11:7]};
  assign bimm       = {inst[31], inst[7], inst[30:25], inst[11:8]};
  assign uimm       = inst[31:12];
  assign jimm       = {inst[31], inst[19:12], inst[20], inst[30:21]};

  // Bubbles never select an extender mode or raise illegal
  always_comb begin
    ext_op  = '0;
    illegal = 1'b0;
    if (valid) begin
      case (opcode)
        OP_IMM:      ext_op = is_shift_funct3(funct3) ? EXT_CTRL_ITYPE_SHAMT : EXT_CTRL_ITYPE;
        LOAD, JALR:  ext_op = EXT_CTRL_ITYPE;
        STORE:       ext_op = EXT_CTRL_STYPE;
        BRANCH:      ext_op = EXT_CTRL_BTYPE;
        LUI, AUIPC:  ext_op = EXT_CTRL_UTYPE;
        JAL:         ext_op = EXT_CTRL_JTYPE;
        OP, SYSTEM:  ext_op = '0;
        default:     illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall (hold) and flush (bubble) control;
// field extraction lives in imm_field_dec.
module if_id_stage #(
  parameter logic [31:0] NOP_INST = if_id_stage_pkg::NOP_INST,
  parameter logic [31:0] PC_RESET = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  input  logic        valid_in,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [4:0]  iimm_shamt,
  output logic [11:0] iimm,
  output logic [11:0] simm,
  output logic [11:0] bimm,
  output logic [19:0] uimm,
  output logic [19:0] jimm,
  output logic [5:0]  EXTOp,
  output logic        illegal
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Flush beats stall; an invalid fetch is latched as a NOP
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      inst_d  = NOP_INST;
      pc_d    = PC_RESET;
      valid_d = 1'b0;
    end else if (!stall) begin
      inst_d  = valid_in ? inst_in : NOP_INST;
      pc_d    = pc_in;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc_q    <= PC_RESET;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign inst_out  = inst_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;
  assign rs1       = inst_q[19:15];
  assign rs2       = inst_q[24:20];
  assign rd        = inst_q[11:7];

  imm_field_dec u_imm_field_dec (
    .inst       (inst_q),
    .valid      (valid_q),
    .iimm_shamt (iimm_shamt),
    .iimm       (iimm),
    .simm       (simm),
    .bimm       (bimm),
    .uimm       (uimm),
    .jimm       (jimm),
    .ext_op     (EXTOp),
    .illegal    (illegal)
  );

endmodule
